multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 No parameters; state encoding, opcode set and latencies SHALL be fixed as specified below.
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_instrCode  in  6  opcode field from instruction register output.
REQ-005 i_memReady  in  1  memory access complete this cycle.
REQ-006 o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite, o_irWrite  out  1 each  PC, memory and IR strobes.
REQ-007 o_memToReg, o_regDst, o_regWrite, o_aluSrcA, o_extOp, o_illegal  out  1 each  register-file, ALU and status controls.
REQ-008 o_aluSrcB  out  2  00 regB, 01 const 4, 10 extended imm, 11 extended imm<<2.
REQ-009 o_aluOp  out  2  00 add, 01 sub, 10 funct decode, 11 opcode (immediate) decode.
REQ-010 o_pcSource  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-011 o_state  out  4  current state code, for debug and verification.

Function
REQ-012 States and codes SHALL be: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11; unused codes 12-15 SHALL go to FETCH on the next edge.
REQ-013 Outputs SHALL be decoded from state; only i_memReady gating (REQ-014, REQ-016, REQ-017) and o_illegal/o_extOp opcode decode SHALL be combinational from inputs; any output not listed for a state SHALL be 0.
REQ-014 FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00; irWrite=pcWrite=i_memReady; stay while i_memReady=0, else go to DECODE.
REQ-015 DECODE: aluSrcA=0, aluSrcB=11, aluOp=00; opcode SHALL be latched into an internal register on this edge, and all later states SHALL use the latched value.
REQ-015a DECODE next state by opcode: 000000 -> R_EXEC; 100011 LW and 101011 SW -> MEM_ADR; 000100 BEQ -> BRANCH; 000010 J -> JUMP; 001000/001001/001100/001101/001010 (ADDI/ADDIU/ANDI/ORI/SLTI) -> IMM_EXEC; any other -> FETCH with o_illegal=1 for that DECODE cycle only.
REQ-016 MEM_ADR: aluSrcA=1, aluSrcB=10, aluOp=00, extOp=1; go to MEM_READ if latched opcode is LW, else MEM_WRITE. MEM_READ: memRead=1, iorD=1; hold until i_memReady=1, then go to MEM_WB. MEM_WB: regWrite=1, memToReg=1, regDst=0; go to FETCH.
REQ-017 MEM_WRITE: memWrite=i_memReady, iorD=1; hold until i_memReady=1, then go to FETCH; memWrite SHALL assert exactly one cycle per SW.
REQ-018 R_EXEC: aluSrcA=1, aluSrcB=00, aluOp=10; go to R_WB. R_WB: regDst=1, regWrite=1, memToReg=0; go to FETCH.
REQ-019 BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01; go to FETCH. JUMP: pcWrite=1, pcSource=10; go to FETCH.
REQ-020 IMM_EXEC: aluSrcA=1, aluSrcB=10, aluOp=11; go to IMM_WB. IMM_WB: aluSrcA=1, aluSrcB=10, aluOp=11, regDst=0, regWrite=1, memToReg=0; go to FETCH.
REQ-021 o_extOp SHALL be 0 in IMM_EXEC and IMM_WB when the latched opcode is ANDI or ORI, and 1 in every other state.
REQ-022 Zero-wait latency in cycles, counted from FETCH through return to FETCH: R 4, LW 5, SW 4, BEQ 3, J 3, immediate 4, illegal 2; each cycle of i_memReady=0 in FETCH, MEM_READ or MEM_WRITE SHALL add exactly 1 cycle.
REQ-023 In any cycle, at most one of o_regWrite and o_memWrite SHALL be 1, and o_pcWrite and o_pcWriteCond SHALL never both be 1.

Reset
REQ-024 While i_rst_n=0, the state SHALL be FETCH (o_state=0), the latched opcode 000000, and all outputs forced to 0, including o_memRead and o_extOp; this SHALL take effect asynchronously.
REQ-025 On release of reset, FETCH outputs SHALL appear in the same cycle; reset asserted mid-instruction SHALL abort it with no further strobes.

Verification
REQ-026 Reset, then opcode 000000 with i_memReady=1 -> o_state 0,1,6,7,0; o_regDst=o_regWrite=1 only in state 7; o_aluOp=10 in state 6.
REQ-027 LW (100011) with i_memReady low for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0; o_memToReg=1 only in state 4; total 7 cycles.
REQ-028 SW (101011), then BEQ (000100), then J (000010) -> SW sequence 0,1,2,5,0 with one o_memWrite pulse; BEQ: o_pcWriteCond=1, o_aluOp=01 in state 8; J: o_pcWrite=1, o_pcSource=10 in state 9.
REQ-029 ORI (001101), then ADDI (001000) -> o_extOp=0 in states 10-11 for ORI and 1 for ADDI; o_regWrite=1 in state 11 only.
REQ-030 Opcode 111111 -> o_illegal=1 for one cycle in state 1, then FETCH; no regWrite, memWrite, pcWrite or pcWriteCond.
REQ-031 Assert i_rst_n=0 between clock edges while in MEM_READ -> o_state=0 and all outputs 0 immediately; FETCH resumes on release.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle processor control unit. The next-state logic follows the opcode.
// The control strobes are decoded from the current state. A few strobes are
// also gated by i_memReady. Reset forces every output low at once.
module multicycle_control (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_instrCode,
  input  logic       i_memReady,
  output logic       o_pcWrite,
  output logic       o_pcWriteCond,
  output logic       o_iorD,
  output logic       o_memRead,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_memToReg,
  output logic       o_regDst,
  output logic       o_regWrite,
  output logic       o_aluSrcA,
  output logic       o_extOp,
  output logic       o_illegal,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_aluOp,
  output logic [1:0] o_pcSource,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    IMM_EXEC  = 4'd10,
    IMM_WB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_t     state;
  state_t     nextState;
  logic [5:0] latchedOp;

  // Immediate-format ALU instructions share the IMM_EXEC/IMM_WB path.
  function automatic logic isImmOp(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_SLTI);
  endfunction

  // Logical immediates take a zero-extended operand.
  function automatic logic isZeroExtOp(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // Any opcode outside the supported set is illegal.
  function automatic logic isLegalOp(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || isImmOp(op);
  endfunction

  // State register and opcode latch. The opcode is captured on the DECODE edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= FETCH;
      latchedOp <= OP_RTYPE;
    end else begin
      state <= nextState;
      if (state == DECODE) latchedOp <= i_instrCode;
    end
  end

  // Next-state selection. DECODE dispatches on the live opcode; later states use the latched copy.
  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:     nextState = i_memReady ? DECODE : FETCH;
      DECODE: begin
        if (i_instrCode == OP_RTYPE)                           nextState = R_EXEC;
        else if ((i_instrCode == OP_LW) || (i_instrCode == OP_SW)) nextState = MEM_ADR;
        else if (i_instrCode == OP_BEQ)                        nextState = BRANCH;
        else if (i_instrCode == OP_J)                          nextState = JUMP;
        else if (isImmOp(i_instrCode))                         nextState = IMM_EXEC;
        else                                                   nextState = FETCH;
      end
      MEM_ADR:   nextState = (latchedOp == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  nextState = i_memReady ? MEM_WB : MEM_READ;
      MEM_WB:    nextState = FETCH;
      MEM_WRITE: nextState = i_memReady ? FETCH : MEM_WRITE;
      R_EXEC:    nextState = R_WB;
      R_WB:      nextState = FETCH;
      BRANCH:    nextState = FETCH;
      JUMP:      nextState = FETCH;
      IMM_EXEC:  nextState = IMM_WB;
      IMM_WB:    nextState = FETCH;
      default:   nextState = FETCH;
    endcase
  end

  // Output decode from the current state. Reset overrides everything, so outputs drop without waiting for a clock.
  always_comb begin
    o_pcWrite     = 1'b0;
    o_pcWriteCond = 1'b0;
    o_iorD        = 1'b0;
    o_memRead     = 1'b0;
    o_memWrite    = 1'b0;
    o_irWrite     = 1'b0;
    o_memToReg    = 1'b0;
    o_regDst      = 1'b0;
    o_regWrite    = 1'b0;
    o_aluSrcA     = 1'b0;
    o_extOp       = 1'b1;
    o_illegal     = 1'b0;
    o_aluSrcB     = 2'b00;
    o_aluOp       = 2'b00;
    o_pcSource    = 2'b00;
    o_state       = state;
    case (state)
      FETCH: begin
        o_memRead = 1'b1;
        o_aluSrcB = 2'b01;
        o_irWrite = i_memReady;
        o_pcWrite = i_memReady;
      end
      DECODE: begin
        o_aluSrcB = 2'b11;
        o_illegal = !isLegalOp(i_instrCode);
      end
      MEM_ADR: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = 2'b10;
      end
      MEM_READ: begin
        o_memRead = 1'b1;
        o_iorD    = 1'b1;
      end
      MEM_WB: begin
        o_regWrite = 1'b1;
        o_memToReg = 1'b1;
      end
      MEM_WRITE: begin
        o_iorD     = 1'b1;
        o_memWrite = i_memReady;
      end
      R_EXEC: begin
        o_aluSrcA = 1'b1;
        o_aluOp   = 2'b10;
      end
      R_WB: begin
        o_regDst   = 1'b1;
        o_regWrite = 1'b1;
      end
      BRANCH: begin
        o_aluSrcA     = 1'b1;
        o_aluOp       = 2'b01;
        o_pcWriteCond = 1'b1;
        o_pcSource    = 2'b01;
      end
      JUMP: begin
        o_pcWrite  = 1'b1;
        o_pcSource = 2'b10;
      end
      IMM_EXEC: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = 2'b10;
        o_aluOp   = 2'b11;
        o_extOp   = !isZeroExtOp(latchedOp);
      end
      IMM_WB: begin
        o_aluSrcA  = 1'b1;
        o_aluSrcB  = 2'b10;
        o_aluOp    = 2'b11;
        o_regWrite = 1'b1;
        o_extOp    = !isZeroExtOp(latchedOp);
      end
      default: begin
      end
    endcase
    if (!i_rst_n) begin
      o_pcWrite     = 1'b0;
      o_pcWriteCond = 1'b0;
      o_iorD        = 1'b0;
      o_memRead     = 1'b0;
      o_memWrite    = 1'b0;
      o_irWrite     = 1'b0;
      o_memToReg    = 1'b0;
      o_regDst      = 1'b0;
      o_regWrite    = 1'b0;
      o_aluSrcA     = 1'b0;
      o_extOp       = 1'b0;
      o_illegal     = 1'b0;
      o_aluSrcB     = 2'b00;
      o_aluOp       = 2'b00;
      o_pcSource    = 2'b00;
      o_state       = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. Each directed cycle queues its expected state and control word.
// A monitor on the falling edge pops each entry and compares it with the DUT outputs.
module tb_multicycle_control;

  logic       clk;
  logic       rstN;
  logic [5:0] instr;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA, extOp, illegal;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  multicycle_control dut (
    .i_clk(clk), .i_rst_n(rstN), .i_instrCode(instr), .i_memReady(memReady),
    .o_pcWrite(pcWrite), .o_pcWriteCond(pcWriteCond), .o_iorD(iorD),
    .o_memRead(memRead), .o_memWrite(memWrite), .o_irWrite(irWrite),
    .o_memToReg(memToReg), .o_regDst(regDst), .o_regWrite(regWrite),
    .o_aluSrcA(aluSrcA), .o_extOp(extOp), .o_illegal(illegal),
    .o_aluSrcB(aluSrcB), .o_aluOp(aluOp), .o_pcSource(pcSource),
    .o_state(state)
  );

  // Control word bit order, MSB to LSB:
  // pcWrite pcWriteCond iorD memRead memWrite irWrite |
  // memToReg regDst regWrite aluSrcA extOp illegal | aluSrcB aluOp pcSource
  logic [17:0] actCtl;
  assign actCtl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                   memToReg, regDst, regWrite, aluSrcA, extOp, illegal,
                   aluSrcB, aluOp, pcSource};

  localparam logic [17:0] C_ZERO   = 18'b000000_000000_000000;
  localparam logic [17:0] C_FRDY   = 18'b100101_000010_010000;
  localparam logic [17:0] C_FWAIT  = 18'b000100_000010_010000;
  localparam logic [17:0] C_DEC    = 18'b000000_000010_110000;
  localparam logic [17:0] C_DECILL = 18'b000000_000011_110000;
  localparam logic [17:0] C_MADR   = 18'b000000_000110_100000;
  localparam logic [17:0] C_MRD    = 18'b001100_000010_000000;
  localparam logic [17:0] C_MWB    = 18'b000000_101010_000000;
  localparam logic [17:0] C_MWRRDY = 18'b001010_000010_000000;
  localparam logic [17:0] C_MWRWT  = 18'b001000_000010_000000;
  localparam logic [17:0] C_REXEC  = 18'b000000_000110_001000;
  localparam logic [17:0] C_RWB    = 18'b000000_011010_000000;
  localparam logic [17:0] C_BR     = 18'b010000_000110_000101;
  localparam logic [17:0] C_JMP    = 18'b100000_000010_000010;
  localparam logic [17:0] C_IEXS   = 18'b000000_000110_101100;
  localparam logic [17:0] C_IEXZ   = 18'b000000_000100_101100;
  localparam logic [17:0] C_IWBS   = 18'b000000_001110_101100;
  localparam logic [17:0] C_IWBZ   = 18'b000000_001100_101100;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [15:0] idx;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   passed = 0;
  int   stepNo = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed cycle: drive inputs just after the rising edge and queue the response expected for this cycle.
  task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [17:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    rstN     = r;
    instr    = op;
    memReady = rdy;
    e.st  = st;
    e.ctl = ctl;
    e.idx = 16'(stepNo);
    expQ.push_back(e);
    stepNo++;
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      total++;
      if (state === e.st) passed++;
      else $display("FAIL cyc%0d state: got %0d want %0d", e.idx, state, e.st);
      total++;
      if (actCtl === e.ctl) passed++;
      else $display("FAIL cyc%0d ctl: got %b want %b", e.idx, actCtl, e.ctl);
      total++;
      if (!(regWrite && memWrite)) passed++;
      else $display("FAIL cyc%0d regWrite/memWrite exclusive: got both 1 want at most one", e.idx);
      total++;
      if (!(pcWrite && pcWriteCond)) passed++;
      else $display("FAIL cyc%0d pcWrite/pcWriteCond exclusive: got both 1 want at most one", e.idx);
    end
  end

  initial begin
    rstN = 1'b0; instr = 6'b000000; memReady = 1'b0;
    // reset held
    step(0, 6'b000000, 0, 4'd0, C_ZERO);
    step(0, 6'b000000, 1, 4'd0, C_ZERO);
    // R-type: 0,1,6,7
    step(1, 6'b000000, 1, 4'd0, C_FRDY);
    step(1, 6'b000000, 1, 4'd1, C_DEC);
    step(1, 6'b000000, 1, 4'd6, C_REXEC);
    step(1, 6'b000000, 1, 4'd7, C_RWB);
    // LW with one fetch wait and two MEM_READ waits; opcode changes after DECODE
    step(1, 6'b100011, 0, 4'd0, C_FWAIT);
    step(1, 6'b100011, 1, 4'd0, C_FRDY);
    step(1, 6'b100011, 1, 4'd1, C_DEC);
    step(1, 6'b101011, 1, 4'd2, C_MADR);
    step(1, 6'b101011, 0, 4'd3, C_MRD);
    step(1, 6'b000000, 0, 4'd3, C_MRD);
    step(1, 6'b000000, 1, 4'd3, C_MRD);
    step(1, 6'b000000, 1, 4'd4, C_MWB);
    // SW with one MEM_WRITE wait; single memWrite pulse
    step(1, 6'b000000, 1, 4'd0, C_FRDY);
    step(1, 6'b101011, 1, 4'd1, C_DEC);
    step(1, 6'b100011, 0, 4'd2, C_MADR);
    step(1, 6'b100011, 0, 4'd5, C_MWRWT);
    step(1, 6'b000000, 1, 4'd5, C_MWRRDY);
    // BEQ
    step(1, 6'b000000, 1, 4'd0, C_FRDY);
    step(1, 6'b000100, 1, 4'd1, C_DEC);
    step(1, 6'b000000, 1, 4'd8, C_BR);
    // J
    step(1, 6'b000000, 1, 4'd0, C_FRDY);
    step(1, 6'b000010, 1, 4'd1, C_DEC);
    step(1, 6'b000000, 1, 4'd9, C_JMP);
    // ORI: zero-extend even while the live opcode shows ADDI
    step(1, 6'b000000, 1, 4'd0, C_FRDY);
    step(1, 6'b001101, 1, 4'd1, C_DEC);
    step(1, 6'b001000, 1, 4'd10, C_IEXZ);
    step(1, 6'b001000, 1, 4'd11, C_IWBZ);
    // ADDI: sign-extend even while the live opcode shows ORI
    step(1, 6'b000000, 1, 4'd0, C_FRDY);
    step(1, 6'b001000, 1, 4'd1, C_DEC);
    step(1, 6'b001101, 1, 4'd10, C_IEXS);
    step(1, 6'b001101, 1, 4'd11, C_IWBS);
    // ANDI
    step(1, 6'b000000, 1, 4'd0, C_FRDY);
    step(1, 6'b001100, 1, 4'd1, C_DEC);
    step(1, 6'b000000, 1, 4'd10, C_IEXZ);
    step(1, 6'b000000, 1, 4'd11, C_IWBZ);
    // illegal opcode
    step(1, 6'b000000, 1, 4'd0, C_FRDY);
    step(1, 6'b111111, 1, 4'd1, C_DECILL);
    step(1, 6'b000000, 1, 4'd0, C_FRDY);
    // LW aborted by reset asserted between edges in MEM_READ
    step(1, 6'b100011, 1, 4'd1, C_DEC);
    step(1, 6'b000000, 1, 4'd2, C_MADR);
    step(1, 6'b000000, 0, 4'd3, C_MRD);
    step(0, 6'b000000, 0, 4'd0, C_ZERO);
    step(1, 6'b000000, 1, 4'd0, C_FRDY);
    step(1, 6'b000000, 1, 4'd1, C_DEC);
    step(1, 6'b000000, 1, 4'd6, C_REXEC);
    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (expQ.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending want 0", expQ.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
